peak_event_queue: RTL and testbench

//   Downstream consumer of max_hold's "max" output. Detects every cycle on which the held

---
 rtl/peak_event_queue.sv | 116 +++++++++++
 tb/tb_peak_event_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/peak_event_queue.sv
// Change-detect event queue behind max_hold: timestamps each change of the held
// maximum and drains {value, timestamp} over valid/ready, counting overflow drops.
module peak_event_queue #(
    parameter int data_width = 3,
    parameter int ts_width   = 16,
    parameter int fifo_depth = 4,
    parameter int drop_width = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            clear,
    input  logic [data_width-1:0]           max_in,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [data_width-1:0]           out_value,
    output logic [ts_width-1:0]             out_timestamp,
    output logic [$clog2(fifo_depth):0]     level,
    output logic                            overflow,
    output logic [drop_width-1:0]           drop_count
);

    localparam int aw = $clog2(fifo_depth);
    localparam int lw = aw + 1;

    typedef struct packed {
        logic [data_width-1:0] value;
        logic [ts_width-1:0]   ts;
    } entry_t;

    entry_t                mem [fifo_depth];
    entry_t                head;
    entry_t                head_next;
    entry_t                new_entry;

    logic [ts_width-1:0]   ts_q;
    logic [data_width-1:0] prev_q;
    logic [aw-1:0]         wr_ptr;
    logic [aw-1:0]         rd_ptr;
    logic [aw-1:0]         rd_next;
    logic [lw-1:0]         level_next;

    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  do_push;
    logic                  drop;

    assign new_entry  = '{value: max_in, ts: ts_q};
    assign push       = (max_in != prev_q);
    assign pop        = out_valid & out_ready;
    assign full       = (level == lw'(fifo_depth));
    assign do_push    = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign level_next = level + lw'(do_push) - lw'(pop);
    assign rd_next    = rd_ptr + aw'(pop);

    // Registered head: whatever will sit at rd_next after this edge.
    always_comb begin
        head_next = head;
        if (pop) begin
            if (level == lw'(1))
                head_next = do_push ? new_entry : '0;
            else
                head_next = mem[rd_next];
        end else if (level == '0 && do_push) begin
            head_next = new_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear)
            mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q       <= '0;
            prev_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head       <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            ts_q       <= '0;
            prev_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head       <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            ts_q      <= ts_q + ts_width'(1);
            prev_q    <= max_in;
            level     <= level_next;
            rd_ptr    <= rd_next;
            head      <= head_next;
            out_valid <= (level_next != '0);
            if (do_push)
                wr_ptr <= wr_ptr + aw'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + drop_width'(1);
            end
        end
    end

    assign out_value     = head.value;
    assign out_timestamp = head.ts;

endmodule

// File: tb/tb_peak_event_queue.sv
// Directed bench for peak_event_queue: default instance plus a narrow
// ts/drop-counter instance for wrap and saturation.
module tb_peak_event_queue;

    logic        clock = 1'b0;
    logic        reset, clear, out_ready;
    logic [2:0]  max_in;
    logic        out_valid, overflow;
    logic [2:0]  out_value, level;
    logic [15:0] out_timestamp;
    logic [7:0]  drop_count;

    logic        reset2, clear2, rdy2;
    logic [2:0]  m2;
    logic        v2, ov2;
    logic [2:0]  val2, lvl2;
    logic [3:0]  ts2;
    logic [1:0]  dc2;

    int checks = 0;
    int errors = 0;
    int ev;
    int maxlvl;

    always #5 clock = ~clock;

    peak_event_queue dut (
        .clock(clock), .reset(reset), .clear(clear), .max_in(max_in),
        .out_ready(out_ready), .out_valid(out_valid), .out_value(out_value),
        .out_timestamp(out_timestamp), .level(level), .overflow(overflow),
        .drop_count(drop_count)
    );

    peak_event_queue #(.ts_width(4), .drop_width(2)) dut2 (
        .clock(clock), .reset(reset2), .clear(clear2), .max_in(m2),
        .out_ready(rdy2), .out_valid(v2), .out_value(val2),
        .out_timestamp(ts2), .level(lvl2), .overflow(ov2),
        .drop_count(dc2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; max_in = 3'd0; out_ready = 1'b0;
        reset2 = 1'b0; clear2 = 1'b0; m2 = 3'd0; rdy2 = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_value", 32'(out_value), 0);
        chk("rst_ts", 32'(out_timestamp), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_count), 0);
        #1 reset = 1'b1;

        // edges with ts 0..4, no change
        repeat (5) step();
        chk("idle_level", 32'(level), 0);
        chk("idle_valid", 32'(out_valid), 0);

        // first event at ts 5
        max_in = 3'd3; out_ready = 1'b1;
        step();
        chk("ev1_valid", 32'(out_valid), 1);
        chk("ev1_value", 32'(out_value), 3);
        chk("ev1_ts", 32'(out_timestamp), 5);
        chk("ev1_level", 32'(level), 1);
        step();
        chk("ev1_pop_valid", 32'(out_valid), 0);
        chk("ev1_pop_level", 32'(level), 0);

        // held value produces exactly one event (ts 7)
        max_in = 3'd5;
        step();
        chk("hold_ts", 32'(out_timestamp), 7);
        ev = int'(out_valid);
        maxlvl = int'(level);
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) ev++;
            if (int'(level) > maxlvl) maxlvl = int'(level);
        end
        chk("hold_events", 32'(ev), 1);
        chk("hold_maxlvl", 32'(maxlvl), 1);

        // overflow: pushes at ts 28..31, drops at 32,33
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            max_in = 3'(i);
            step();
            if (i == 4) chk("ovf_full_level", 32'(level), 4);
            if (i >= 2) chk("ovf_hold_value", 32'(out_value), 1);
        end
        chk("ovf_level", 32'(level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drop", 32'(drop_count), 2);
        chk("ovf_head_ts", 32'(out_timestamp), 28);

        // full with push and pop together at ts 34
        out_ready = 1'b1; max_in = 3'd7;
        step();
        chk("pp_level", 32'(level), 4);
        chk("pp_drop", 32'(drop_count), 2);
        chk("pp_value", 32'(out_value), 2);
        chk("pp_ts", 32'(out_timestamp), 29);
        step();
        chk("drain_v3", 32'(out_value), 3);
        chk("drain_t3", 32'(out_timestamp), 30);
        step();
        chk("drain_v4", 32'(out_value), 4);
        chk("drain_t4", 32'(out_timestamp), 31);
        step();
        chk("drain_v7", 32'(out_value), 7);
        chk("drain_t7", 32'(out_timestamp), 34);
        chk("drain_l1", 32'(level), 1);
        step();
        chk("drain_empty", 32'(out_valid), 0);
        chk("drain_l0", 32'(level), 0);
        chk("drain_ovf", 32'(overflow), 1);

        // push and pop together at level 1 (ts 39, 40)
        out_ready = 1'b0; max_in = 3'd1;
        step();
        chk("l1_value", 32'(out_value), 1);
        out_ready = 1'b1; max_in = 3'd2;
        step();
        chk("l1_pp_valid", 32'(out_valid), 1);
        chk("l1_pp_value", 32'(out_value), 2);
        chk("l1_pp_ts", 32'(out_timestamp), 40);
        chk("l1_pp_level", 32'(level), 1);

        // synchronous clear beats a concurrent change
        out_ready = 1'b0; clear = 1'b1; max_in = 3'd6;
        step();
        chk("clr_level", 32'(level), 0);
        chk("clr_valid", 32'(out_valid), 0);
        chk("clr_value", 32'(out_value), 0);
        chk("clr_ts", 32'(out_timestamp), 0);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_drop", 32'(drop_count), 0);
        clear = 1'b0; max_in = 3'd0;
        step();
        chk("clr_noev", 32'(level), 0);
        max_in = 3'd3;
        step();
        chk("clr_ev_ts", 32'(out_timestamp), 1);
        chk("clr_ev_value", 32'(out_value), 3);

        // asynchronous reset mid-stream with 3 queued
        max_in = 3'd1;
        step();
        max_in = 3'd2;
        step();
        chk("q3_level", 32'(level), 3);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_level", 32'(level), 0);
        chk("ar_value", 32'(out_value), 0);
        chk("ar_ts", 32'(out_timestamp), 0);
        max_in = 3'd0;
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("ar_after_level", 32'(level), 0);
        chk("ar_after_valid", 32'(out_valid), 0);

        // narrow instance: timestamp wrap and drop saturation
        reset2 = 1'b1;
        repeat (17) step();
        chk("w_idle", 32'(lvl2), 0);
        m2 = 3'd7; rdy2 = 1'b1;
        step();
        chk("w_valid", 32'(v2), 1);
        chk("w_value", 32'(val2), 7);
        chk("w_ts", 32'(ts2), 1);
        m2 = 3'd0;
        step();
        chk("w_zero_valid", 32'(v2), 1);
        chk("w_zero_value", 32'(val2), 0);
        chk("w_zero_ts", 32'(ts2), 2);
        chk("w_zero_level", 32'(lvl2), 1);
        rdy2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m2 = (i % 2 == 1) ? 3'd2 : 3'd1;
            step();
        end
        chk("sat_level", 32'(lvl2), 4);
        chk("sat_ovf", 32'(ov2), 1);
        chk("sat_drop", 32'(dc2), 3);
        chk("sat_head", 32'(ts2), 2);
        clear2 = 1'b1;
        step();
        chk("c2_level", 32'(lvl2), 0);
        chk("c2_drop", 32'(dc2), 0);
        chk("c2_ovf", 32'(ov2), 0);
        chk("c2_valid", 32'(v2), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
